// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: operand reads, destination reservation,
// writeback ports and the scoreboard vector. Issue/writeback logic uses
// the master view; the register file uses the slave view.
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NR_READ  = 2,
    parameter int NR_WRITE = 1
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NR_READ*ADDR_W-1:0]  rs_addr_i;
    logic [NR_READ*DATA_W-1:0]  rs_data_o;
    logic [NR_READ-1:0]         rs_busy_o;
    logic                       rsv_valid_i;
    logic [ADDR_W-1:0]          rsv_addr_i;
    logic [NR_WRITE-1:0]        rd_we_i;
    logic [NR_WRITE*ADDR_W-1:0] rd_addr_i;
    logic [NR_WRITE*DATA_W-1:0] rd_data_i;
    logic [NUM_REGS-1:0]        busy_o;

    modport master (
        output rs_addr_i, rsv_valid_i, rsv_addr_i, rd_we_i, rd_addr_i, rd_data_i,
        input  rs_data_o, rs_busy_o, busy_o
    );

    modport slave (
        input  rs_addr_i, rsv_valid_i, rsv_addr_i, rd_we_i, rd_addr_i, rd_data_i,
        output rs_data_o, rs_busy_o, busy_o
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register
// pending-write scoreboard. Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, read ports
// see same-cycle writeback data and a same-cycle write hides the busy bit.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NR_READ  = 2,
    parameter int NR_WRITE = 1
) (
    input logic         clk_i,
    input logic         rst_ni,
    regfile_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    // Storage exists only for registers 1..NUM_REGS-1.
    logic [DATA_W-1:0]   regs    [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy_q;

    // Per-register decode of this cycle's writeback and reservation.
    logic [DATA_W-1:0]   wr_data [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] wr_hit;
    logic [NUM_REGS-1:1] rsv_hit;

    logic [NR_READ*DATA_W-1:0] rs_data;
    logic [NR_READ-1:0]        rs_busy;

    // Decode write ports per register; later (higher-index) ports override
    // earlier ones. Addresses 0 and >= NUM_REGS match no register.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
            rsv_hit[r] = bus.rsv_valid_i && (bus.rsv_addr_i == ADDR_W'(r));
            for (int w = 0; w < NR_WRITE; w++) begin
                if (bus.rd_we_i[w] && (bus.rd_addr_i[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = bus.rd_data_i[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Commit writes and update the scoreboard; a reservation beats a
    // same-cycle write because it names a new producer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
                if (rsv_hit[r]) begin
                    busy_q[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read mux per port; unmatched addresses read 0, not busy.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int p = 0; p < NR_READ; p++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.rs_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rs_data[p*DATA_W +: DATA_W] = regs[r];
                    rs_busy[p]                  = busy_q[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            for (int r = 1; r < NUM_REGS; r++) begin
                if ((bus.rs_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) && wr_hit[r]) begin
                    rs_data[p*DATA_W +: DATA_W] = wr_data[r];
                    rs_busy[p]                  = rsv_hit[r];
                end
            end
`endif
        end
    end

    assign bus.rs_data_o = rs_data;
    assign bus.rs_busy_o = rs_busy;
    assign bus.busy_o    = {busy_q, 1'b0};
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (24 registers, 2 read, 2 write ports).
module tb_regfile_mp;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 24;
    localparam int NR_READ  = 2;
    localparam int NR_WRITE = 2;
    localparam int ADDR_W   = 5;

    typedef struct {
        logic [DATA_W-1:0]   d0;
        logic [DATA_W-1:0]   d1;
        logic [1:0]          rb;
        logic [NUM_REGS-1:0] bv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    logic [DATA_W-1:0]   m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_busy;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NR_READ(NR_READ), .NR_WRITE(NR_WRITE)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NR_READ(NR_READ), .NR_WRITE(NR_WRITE)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rs_addr_i   = '0;
        bus.rsv_valid_i = 1'b0;
        bus.rsv_addr_i  = '0;
        bus.rd_we_i     = '0;
        bus.rd_addr_i   = '0;
        bus.rd_data_i   = '0;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        bus.rs_addr_i[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic wr(input int w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.rd_we_i[w]                    = 1'b1;
        bus.rd_addr_i[w*ADDR_W +: ADDR_W] = a;
        bus.rd_data_i[w*DATA_W +: DATA_W] = d;
    endtask

    task automatic rsv(input logic [ADDR_W-1:0] a);
        bus.rsv_valid_i = 1'b1;
        bus.rsv_addr_i  = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            set_rd(0, ADDR_W'(a));
            set_rd(1, ADDR_W'(31 - a));
            #1;
            total++;
            if (bus.rs_data_o !== '0 || bus.rs_busy_o !== 2'b00) begin
                bad++;
                $display("FAIL reset_read addr=%0d: got data=%h busy=%b want 0/00", a, bus.rs_data_o, bus.rs_busy_o);
            end
        end
        total++;
        if (bus.busy_o !== '0) begin
            bad++;
            $display("FAIL reset_busy: got %h want 0", bus.busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_x0();
        tick(); idle();
        wr(0, 5'd0, 32'hDEADBEEF);
        rsv(5'd0);
        tick(); idle();
        set_rd(0, 5'd0);
        #3;
        total++;
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h0 || bus.busy_o !== '0) begin
            bad++;
            $display("FAIL x0_write: got data=%h busy_o=%h want 0/0", bus.rs_data_o[DATA_W-1:0], bus.busy_o);
        end
    endtask

    task automatic test_write_priority();
        tick(); idle();
        wr(0, 5'd5, 32'h11);
        wr(1, 5'd5, 32'h22);
        tick(); idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd5);
        #3;
        total++;
        if (bus.rs_data_o !== {32'h22, 32'h22}) begin
            bad++;
            $display("FAIL wr_priority x5: got %h want 0x22 on both ports", bus.rs_data_o);
        end
    endtask

    task automatic test_reserve_clear();
        tick(); idle();
        rsv(5'd7);
        tick(); idle();
        set_rd(0, 5'd7);
        #3;
        total++;
        if (bus.busy_o !== 24'h000080 || bus.rs_busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL reserve_x7: got busy_o=%h rs_busy=%b want 000080/1", bus.busy_o, bus.rs_busy_o[0]);
        end
        tick(); idle();
        set_rd(0, 5'd7);
        wr(0, 5'd7, 32'h55);
        #3;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h55 || bus.rs_busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL wr_x7_same_cycle: got data=%h busy=%b want 55/0", bus.rs_data_o[DATA_W-1:0], bus.rs_busy_o[0]);
        end
`else
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h0 || bus.rs_busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL wr_x7_same_cycle: got data=%h busy=%b want 0/1", bus.rs_data_o[DATA_W-1:0], bus.rs_busy_o[0]);
        end
`endif
        tick(); idle();
        set_rd(0, 5'd7);
        #3;
        total++;
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h55 || bus.busy_o !== '0 || bus.rs_busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL wr_clears_x7: got data=%h busy_o=%h rs_busy=%b want 55/0/0", bus.rs_data_o[DATA_W-1:0], bus.busy_o, bus.rs_busy_o[0]);
        end
    endtask

    task automatic test_reserve_wins();
        tick(); idle();
        rsv(5'd9);
        tick(); idle();
        rsv(5'd9);
        wr(1, 5'd9, 32'hA5);
        set_rd(1, 5'd9);
        #3;
        total++;
        if (bus.rs_busy_o[1] !== 1'b1) begin
            bad++;
            $display("FAIL rsv_wr_x9_busy_same_cycle: got %b want 1", bus.rs_busy_o[1]);
        end
        tick(); idle();
        set_rd(1, 5'd9);
        #3;
        total++;
        if (bus.rs_data_o[2*DATA_W-1:DATA_W] !== 32'hA5 || bus.busy_o !== 24'h000200) begin
            bad++;
            $display("FAIL rsv_wins_x9: got data=%h busy_o=%h want a5/000200", bus.rs_data_o[2*DATA_W-1:DATA_W], bus.busy_o);
        end
    endtask

    task automatic test_bypass();
        tick(); idle();
        wr(0, 5'd3, 32'h0BAD);
        tick(); idle();
        rsv(5'd3);
        tick(); idle();
        set_rd(0, 5'd3);
        wr(0, 5'd3, 32'h1234);
        #3;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h1234 || bus.rs_busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_x3: got data=%h busy=%b want 1234/0", bus.rs_data_o[DATA_W-1:0], bus.rs_busy_o[0]);
        end
`else
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h0BAD || bus.rs_busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL nobypass_x3: got data=%h busy=%b want 0bad/1", bus.rs_data_o[DATA_W-1:0], bus.rs_busy_o[0]);
        end
`endif
        tick(); idle();
        set_rd(0, 5'd3);
        #3;
        total++;
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h1234 || bus.rs_busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL after_wr_x3: got data=%h busy=%b want 1234/0", bus.rs_data_o[DATA_W-1:0], bus.rs_busy_o[0]);
        end
    endtask

    task automatic test_out_of_range();
        tick(); idle();
        wr(0, 5'd30, 32'hFFFF_FFFF);
        wr(1, 5'd24, 32'hCAFE_0000);
        rsv(5'd30);
        tick(); idle();
        set_rd(0, 5'd30);
        set_rd(1, 5'd24);
        #3;
        total++;
        if (bus.rs_data_o !== '0 || bus.rs_busy_o !== 2'b00 || bus.busy_o !== 24'h000200) begin
            bad++;
            $display("FAIL out_of_range: got data=%h rs_busy=%b busy_o=%h want 0/00/000200", bus.rs_data_o, bus.rs_busy_o, bus.busy_o);
        end
        set_rd(0, 5'd5);
        set_rd(1, 5'd14);
        #1;
        total++;
        if (bus.rs_data_o !== {32'h0, 32'h22}) begin
            bad++;
            $display("FAIL oor_no_alias: got %h want x14=0 x5=22", bus.rs_data_o);
        end
    endtask

    task automatic test_async_reset();
        tick(); idle();
        wr(0, 5'd6, 32'h66);
        tick(); idle();
        set_rd(0, 5'd6);
        set_rd(1, 5'd9);
        #1;
        total++;
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h66 || bus.rs_busy_o[1] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_state: got x6=%h x9busy=%b want 66/1", bus.rs_data_o[DATA_W-1:0], bus.rs_busy_o[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy_o !== '0 || bus.rs_data_o !== '0 || bus.rs_busy_o !== 2'b00) begin
            bad++;
            $display("FAIL async_reset: got busy_o=%h data=%h rs_busy=%b want 0/0/00", bus.busy_o, bus.rs_data_o, bus.rs_busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        wr(0, 5'd4, 32'h44);
        tick(); idle();
        set_rd(0, 5'd4);
        #3;
        total++;
        if (bus.rs_data_o[DATA_W-1:0] !== 32'h44) begin
            bad++;
            $display("FAIL first_write_after_reset: got %h want 44", bus.rs_data_o[DATA_W-1:0]);
        end
    endtask

    function automatic void exp_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (a != 0 && int'(a) < NUM_REGS) begin
            d = m_regs[int'(a)];
            b = m_busy[int'(a)];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NR_WRITE; w++) begin
                if (bus.rd_we_i[w] && bus.rd_addr_i[w*ADDR_W +: ADDR_W] == a) begin
                    d = bus.rd_data_i[w*DATA_W +: DATA_W];
                    b = bus.rsv_valid_i && (bus.rsv_addr_i == a);
                end
            end
`endif
        end
    endfunction

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 31));
        return ADDR_W'($urandom_range(0, 7));
    endfunction

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        logic [DATA_W-1:0]   nregs [NUM_REGS];
        logic [NUM_REGS-1:0] hit;
        tick(); idle();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
        m_busy = '0;
        for (int c = 0; c < 200; c++) begin
            tick(); idle();
            for (int w = 0; w < NR_WRITE; w++) begin
                if ($urandom_range(0, 1) == 1) wr(w, rnd_addr(), $urandom());
            end
            if ($urandom_range(0, 2) == 0) rsv(rnd_addr());
            set_rd(0, rnd_addr());
            set_rd(1, rnd_addr());
            exp_read(bus.rs_addr_i[ADDR_W-1:0], e.d0, e.rb[0]);
            exp_read(bus.rs_addr_i[2*ADDR_W-1:ADDR_W], e.d1, e.rb[1]);
            e.bv = m_busy;
            exp_q.push_back(e);
            #3;
            got.d0 = bus.rs_data_o[DATA_W-1:0];
            got.d1 = bus.rs_data_o[2*DATA_W-1:DATA_W];
            got.rb = bus.rs_busy_o;
            got.bv = bus.busy_o;
            e = exp_q.pop_front();
            total++;
            if (got.d0 !== e.d0 || got.d1 !== e.d1 || got.rb !== e.rb || got.bv !== e.bv) begin
                bad++;
                $display("FAIL random cycle %0d: got d0=%h d1=%h rb=%b bv=%h want d0=%h d1=%h rb=%b bv=%h",
                         c, got.d0, got.d1, got.rb, got.bv, e.d0, e.d1, e.rb, e.bv);
            end
            for (int r = 0; r < NUM_REGS; r++) nregs[r] = m_regs[r];
            hit = '0;
            for (int w = 0; w < NR_WRITE; w++) begin
                if (bus.rd_we_i[w] && bus.rd_addr_i[w*ADDR_W +: ADDR_W] != 0 &&
                    int'(bus.rd_addr_i[w*ADDR_W +: ADDR_W]) < NUM_REGS) begin
                    nregs[int'(bus.rd_addr_i[w*ADDR_W +: ADDR_W])] = bus.rd_data_i[w*DATA_W +: DATA_W];
                    hit[int'(bus.rd_addr_i[w*ADDR_W +: ADDR_W])]   = 1'b1;
                end
            end
            for (int r = 1; r < NUM_REGS; r++) begin
                m_regs[r] = nregs[r];
                if (bus.rsv_valid_i && int'(bus.rsv_addr_i) == r) m_busy[r] = 1'b1;
                else if (hit[r]) m_busy[r] = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_x0();
        test_write_priority();
        test_reserve_clear();
        test_reserve_wins();
        test_bypass();
        test_out_of_range();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard; successor to the single-write, two-read core register file. Sits between decode/issue and writeback: issue reads operands and reserves destinations, writeback ports commit results and clear reservations. Register 0 is hardwired to zero.

## Interface

- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (2..64, need not be a power of two)
- NR_READ, 2, number of read ports (1..4)
- NR_WRITE, 1, number of write ports (1..4)
- ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable

- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; asynchronous assertion, active-low
- rs_addr_i  in  NR_READ*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rs_data_o  out  NR_READ*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rs_busy_o  out  NR_READ  addressed register has a pending write
- rsv_valid_i  in  1  reserve destination this cycle
- rsv_addr_i  in  ADDR_W  register to reserve
- rd_we_i  in  NR_WRITE  write enable per write port
- rd_addr_i  in  NR_WRITE*ADDR_W  write addresses, packed as rs_addr_i
- rd_data_i  in  NR_WRITE*DATA_W  write data, packed as rs_data_o
- busy_o  out  NUM_REGS  full scoreboard vector, bit r = register r pending

## Operation

- Storage: NUM_REGS-1 flops of DATA_W (regs 1..NUM_REGS-1); reg 0 has no storage, reads 0, busy_o[0] constant 0.
- Write: at clock edge, reg r (r≠0) loads rd_data_i of the highest-index port w with rd_we_i[w] and rd_addr_i[w]==r; otherwise holds.
- Writes and reservations to address 0 or to addresses ≥ NUM_REGS are ignored.
- Read: combinational from rs_addr_i; address 0 or ≥ NUM_REGS returns 0 and busy 0.
- Scoreboard, per reg r≠0, next state:
  - set if rsv_valid_i and rsv_addr_i==r (reserve wins over a same-cycle write to r: new producer);
  - else cleared if any write port writes r;
  - else hold.
- Reserving an already-busy register leaves it busy (no counting; one outstanding producer per register is the issue stage's responsibility).
- Write to a non-busy register is legal: data updates, busy stays 0.
- rs_busy_o[p] = busy_o[rs_addr_i[p]] (modified under REGFILE_BYPASS_EN, below).

## Timing

- Reset (rst_ni low, asynchronous): all registers 0, busy_o all 0; hence rs_data_o 0, rs_busy_o 0. Reset mid-operation discards pending reservations and in-flight writes immediately; first write takes effect on the first rising edge after rst_ni deasserts.
- Write-to-read latency: 1 cycle (new value visible on the cycle after the write edge) without bypass; 0 cycles with bypass.
- Reserve-to-busy latency: 1 cycle; busy_o updates on the edge sampling rsv_valid_i.
- Write-clears-busy: busy_o falls on the edge sampling the write.
- No handshakes; every input is sampled each cycle.

## Configuration

- REGFILE_BYPASS_EN defined: read port p, if any write port writes rs_addr_i[p] (≠0, < NUM_REGS) this cycle, returns the winning (highest-index) port's rd_data_i, and rs_busy_o[p] = 0 unless rsv_valid_i reserves the same register this cycle. busy_o is never bypassed.
- Undefined: reads return stored value only; rs_busy_o[p] = busy_o[rs_addr_i[p]]; no combinational path from rd_* to rs_*.

## Test plan

- Reset then read all addresses on every read port -> all rs_data_o 0, busy_o 0; write 0xDEADBEEF to x0 -> x0 still reads 0.
- NR_WRITE=2: both ports write x5 same cycle, port0 0x11, port1 0x22 -> x5 reads 0x22 next cycle.
- Reserve x7, next cycle busy_o[7]=1 and rs_busy_o=1 reading x7; write x7=0x55 -> busy_o[7]=0 after edge, reads 0x55.
- Same cycle reserve x9 and write x9=0xA5 while x9 busy -> x9=0xA5, busy_o[9] stays 1.
- Write x3=0x1234 while reading x3: without REGFILE_BYPASS_EN read returns old value that cycle, 0x1234 next; with it, 0x1234 same cycle and rs_busy_o 0.
- NUM_REGS=24: write/reserve address 30 -> no state change; read address 30 -> 0, busy 0; assert rst_ni low mid-run with busy bits set -> busy_o 0 and data 0 without waiting for a clock edge.
